// File: rtl/ipm2t_hssthp_rst_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ipm2t_hssthp_rst_pkg
// Purpose  : Shared definitions for the HSST reset/status debounce filter:
//            per-channel FSM state encoding and synchroniser depth limit.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package ipm2t_hssthp_rst_pkg;

    typedef logic [1:0] deb_state_t;

    localparam deb_state_t DEASSERTED = 2'd0;
    localparam deb_state_t RISE_QUAL  = 2'd1;
    localparam deb_state_t ASSERTED   = 2'd2;
    localparam deb_state_t FALL_QUAL  = 2'd3;

    // Deepest input synchroniser supported by the channel.
    localparam int MAX_SYNC_STAGES = 3;

endpackage
`default_nettype wire

// File: rtl/ipm2t_hssthp_rst_debounce_ch.sv
`default_nettype none
// ============================================================================
// Module   : ipm2t_hssthp_rst_debounce_ch
// Purpose  : One debounce channel: input synchroniser, bidirectional
//            qualification FSM with stable-time counter, edge pulses and a
//            sticky glitch flag.
// Ports    : clk           - clock
//            rst_n         - synchronous active-low reset
//            signal_b      - raw status input
//            glitch_clr    - one-cycle clear of glitch_sticky
//            signal_deb    - debounced level, raw polarity
//            deb_rise      - 1-cycle pulse on normalised assertion
//            deb_fall      - 1-cycle pulse on normalised deassertion
//            glitch_sticky - set on any aborted qualification
//            d_next        - next-state normalised level (feeds all_deb)
// Revision : 1.0 - initial release
// ============================================================================
module ipm2t_hssthp_rst_debounce_ch
    import ipm2t_hssthp_rst_pkg::*;
#(
    parameter int   CNTR_WIDTH  = 12,
    parameter int   RISE_VALUE  = 2048,
    parameter int   FALL_VALUE  = 1,
    parameter int   SYNC_STAGES = 2,
    parameter logic POLARITY    = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic signal_b,
    input  logic glitch_clr,
    output logic signal_deb,
    output logic deb_rise,
    output logic deb_fall,
    output logic glitch_sticky,
    output logic d_next
);

    localparam logic [CNTR_WIDTH-1:0] C_ONE  = CNTR_WIDTH'(1);
    localparam logic [CNTR_WIDTH-1:0] C_RISE = CNTR_WIDTH'(RISE_VALUE);
    localparam logic [CNTR_WIDTH-1:0] C_FALL = CNTR_WIDTH'(FALL_VALUE);

    logic n_s;

    // Synchroniser flops reset to the channel's deasserted raw level so the
    // normalised view is 0 straight out of reset.
    generate
        if (SYNC_STAGES == 0) begin : g_sync_bypass
            assign n_s = signal_b ^ POLARITY;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sync_q;
            logic [SYNC_STAGES-1:0] sync_d;

            always_comb begin
                sync_d    = sync_q << 1;
                sync_d[0] = signal_b;
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    sync_q <= {SYNC_STAGES{POLARITY}};
                end else begin
                    sync_q <= sync_d;
                end
            end

            assign n_s = sync_q[SYNC_STAGES-1] ^ POLARITY;
        end
    endgenerate

    deb_state_t            state_q, state_d;
    logic [CNTR_WIDTH-1:0] cnt_q, cnt_d, cnt_inc;
    logic                  d_q, d_d;
    logic                  rise_q, rise_d;
    logic                  fall_q, fall_d;
    logic                  sticky_q, sticky_d;
    logic                  glitch;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        d_d     = d_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        glitch  = 1'b0;
        cnt_inc = cnt_q + C_ONE;

        case (state_q)
            DEASSERTED: begin
                if (n_s) begin
                    if (RISE_VALUE == 1) begin
                        state_d = ASSERTED;
                        d_d     = 1'b1;
                        rise_d  = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        state_d = RISE_QUAL;
                        cnt_d   = C_ONE;
                    end
                end
            end
            RISE_QUAL: begin
                if (n_s) begin
                    if (cnt_inc == C_RISE) begin
                        state_d = ASSERTED;
                        d_d     = 1'b1;
                        rise_d  = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = cnt_inc;
                    end
                end else begin
                    state_d = DEASSERTED;
                    cnt_d   = '0;
                    glitch  = 1'b1;
                end
            end
            ASSERTED: begin
                if (!n_s) begin
                    if (FALL_VALUE == 1) begin
                        state_d = DEASSERTED;
                        d_d     = 1'b0;
                        fall_d  = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        state_d = FALL_QUAL;
                        cnt_d   = C_ONE;
                    end
                end
            end
            FALL_QUAL: begin
                if (!n_s) begin
                    if (cnt_inc == C_FALL) begin
                        state_d = DEASSERTED;
                        d_d     = 1'b0;
                        fall_d  = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = cnt_inc;
                    end
                end else begin
                    state_d = ASSERTED;
                    cnt_d   = '0;
                    glitch  = 1'b1;
                end
            end
            default: begin
                state_d = DEASSERTED;
                cnt_d   = '0;
                d_d     = 1'b0;
            end
        endcase

        // A new glitch outranks a simultaneous clear.
        sticky_d = (sticky_q & ~glitch_clr) | glitch;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= DEASSERTED;
            cnt_q    <= '0;
            d_q      <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            d_q      <= d_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            sticky_q <= sticky_d;
        end
    end

    assign signal_deb    = d_q ^ POLARITY;
    assign deb_rise      = rise_q;
    assign deb_fall      = fall_q;
    assign glitch_sticky = sticky_q;
    assign d_next        = d_d;

endmodule
`default_nettype wire

// File: rtl/ipm2t_hssthp_rst_debounce_mc.sv
`default_nettype none
// ============================================================================
// Module   : ipm2t_hssthp_rst_debounce_mc
// Purpose  : Multi-channel bidirectional debounce filter for HSST reset and
//            status inputs (PLL lock, CDR lock, signal detect).
// Ports    : clk           - clock for all logic
//            rst_n         - synchronous active-low reset
//            signal_b      - raw status inputs [CH_NUM]
//            glitch_clr    - one-cycle clear of all glitch_sticky bits
//            signal_deb    - debounced levels, raw polarity [CH_NUM]
//            deb_rise      - assertion pulses [CH_NUM]
//            deb_fall      - deassertion pulses [CH_NUM]
//            glitch_sticky - aborted-qualification flags [CH_NUM]
//            all_deb       - AND of all normalised debounced levels
// Revision : 1.0 - initial release
// ============================================================================
module ipm2t_hssthp_rst_debounce_mc
    import ipm2t_hssthp_rst_pkg::*;
#(
    parameter int                CH_NUM      = 4,
    parameter int                CNTR_WIDTH  = 12,
    parameter int                RISE_VALUE  = 2048,
    parameter int                FALL_VALUE  = 1,
    parameter int                SYNC_STAGES = 2,
    parameter logic [CH_NUM-1:0] ACTIVE_HIGH = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CH_NUM-1:0] signal_b,
    input  logic              glitch_clr,
    output logic [CH_NUM-1:0] signal_deb,
    output logic [CH_NUM-1:0] deb_rise,
    output logic [CH_NUM-1:0] deb_fall,
    output logic [CH_NUM-1:0] glitch_sticky,
    output logic              all_deb
);

    logic [CH_NUM-1:0] d_next;
    logic              all_deb_q;
    logic              all_deb_d;

    generate
        for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
            ipm2t_hssthp_rst_debounce_ch #(
                .CNTR_WIDTH  (CNTR_WIDTH),
                .RISE_VALUE  (RISE_VALUE),
                .FALL_VALUE  (FALL_VALUE),
                .SYNC_STAGES (SYNC_STAGES),
                .POLARITY    (ACTIVE_HIGH[i])
            ) u_ch (
                .clk           (clk),
                .rst_n         (rst_n),
                .signal_b      (signal_b[i]),
                .glitch_clr    (glitch_clr),
                .signal_deb    (signal_deb[i]),
                .deb_rise      (deb_rise[i]),
                .deb_fall      (deb_fall[i]),
                .glitch_sticky (glitch_sticky[i]),
                .d_next        (d_next[i])
            );
        end
    endgenerate

    // Built from the channels' next-state levels so all_deb moves on the
    // same edge as the individual debounced outputs.
    always_comb begin
        all_deb_d = &d_next;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            all_deb_q <= 1'b0;
        end else begin
            all_deb_q <= all_deb_d;
        end
    end

    assign all_deb = all_deb_q;

endmodule
`default_nettype wire

// File: tb/tb_ipm2t_hssthp_rst_debounce_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_ipm2t_hssthp_rst_debounce_mc
// Purpose  : Directed self-checking bench for the multi-channel debounce
//            filter (2 channels, rise 8, fall 4, 2 sync stages, ch1 active
//            low) plus a second instance with rise/fall 1 and no synchroniser.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ipm2t_hssthp_rst_debounce_mc;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       glitch_clr;
    logic [1:0] signal_b;
    logic [1:0] signal_deb, deb_rise, deb_fall, glitch_sticky;
    logic       all_deb;

    logic [1:0] sb_f;
    logic [1:0] deb_f, rise_f, fall_f, sticky_f;
    logic       all_f;

    always #5 clk = ~clk;

    ipm2t_hssthp_rst_debounce_mc #(
        .CH_NUM(2), .CNTR_WIDTH(12), .RISE_VALUE(8), .FALL_VALUE(4),
        .SYNC_STAGES(2), .ACTIVE_HIGH(2'b10)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .signal_b(signal_b), .glitch_clr(glitch_clr),
        .signal_deb(signal_deb), .deb_rise(deb_rise), .deb_fall(deb_fall),
        .glitch_sticky(glitch_sticky), .all_deb(all_deb)
    );

    ipm2t_hssthp_rst_debounce_mc #(
        .CH_NUM(2), .CNTR_WIDTH(12), .RISE_VALUE(1), .FALL_VALUE(1),
        .SYNC_STAGES(0), .ACTIVE_HIGH(2'b10)
    ) u_dut_fast (
        .clk(clk), .rst_n(rst_n), .signal_b(sb_f), .glitch_clr(glitch_clr),
        .signal_deb(deb_f), .deb_rise(rise_f), .deb_fall(fall_f),
        .glitch_sticky(sticky_f), .all_deb(all_f)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Pulse counters, sampled away from the active edge.
    int rise0 = 0;
    int rise1 = 0;
    int fall0 = 0;
    always @(negedge clk) begin
        if (deb_rise[0]) rise0++;
        if (deb_rise[1]) rise1++;
        if (deb_fall[0]) fall0++;
    end

    // Scoreboard: expectations queued when stimulus is applied.
    string       tag_q[$];
    logic [31:0] exp_q[$];

    task automatic push_exp(input string t, input logic [31:0] v);
        tag_q.push_back(t);
        exp_q.push_back(v);
    endtask

    task automatic check(input logic [31:0] obs);
        string       t;
        logic [31:0] e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty: observed %0h required an entry", obs);
        end else begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            assert (obs === e) else begin
                n_fail++;
                $error("FAIL %s: observed %0h expected %0h", t, obs, e);
            end
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s;
        int s1;
        rst_n      = 1'b0;
        glitch_clr = 1'b0;
        signal_b   = 2'($urandom);
        sb_f       = 2'b10;

        // Reset with random inputs.
        push_exp("rst_signal_deb", 'b10);
        push_exp("rst_deb_rise",   'b00);
        push_exp("rst_deb_fall",   'b00);
        push_exp("rst_sticky",     'b00);
        push_exp("rst_all_deb",    'b0);
        cyc(1); signal_b = 2'($urandom);
        cyc(1); signal_b = 2'($urandom);
        cyc(1);
        check(32'(signal_deb));
        check(32'(deb_rise));
        check(32'(deb_fall));
        check(32'(glitch_sticky));
        check(32'(all_deb));
        signal_b = 2'b10;
        rst_n    = 1'b1;
        cyc(4);

        // Clean rise on ch0: level changes at e0+9.
        s = rise0;
        signal_b[0] = 1'b1;
        push_exp("rise_early_deb",   'b10);
        push_exp("rise_early_count", 0);
        push_exp("rise_deb",         'b11);
        push_exp("rise_pulse",       'b01);
        push_exp("rise_sticky",      'b00);
        push_exp("rise_count",       1);
        cyc(9);
        check(32'(signal_deb));
        check(rise0 - s);
        cyc(1);
        check(32'(signal_deb));
        check(32'(deb_rise));
        check(32'(glitch_sticky));
        cyc(1);
        check(rise0 - s);

        // Fall filter: 3 low samples then high again.
        s = fall0;
        signal_b[0] = 1'b0;
        cyc(3);
        signal_b[0] = 1'b1;
        push_exp("ffilt_deb",    'b11);
        push_exp("ffilt_sticky", 'b01);
        push_exp("ffilt_fall",   0);
        cyc(6);
        check(32'(signal_deb));
        check(32'(glitch_sticky));
        check(fall0 - s);

        glitch_clr = 1'b1;
        push_exp("clr_sticky", 'b00);
        cyc(1);
        glitch_clr = 1'b0;
        check(32'(glitch_sticky));

        // Steady fall: level changes at e0+5.
        s = fall0;
        signal_b[0] = 1'b0;
        push_exp("fall_early_deb", 'b11);
        push_exp("fall_deb",       'b10);
        push_exp("fall_pulse",     'b01);
        push_exp("fall_count",     1);
        cyc(5);
        check(32'(signal_deb));
        cyc(1);
        check(32'(signal_deb));
        check(32'(deb_fall));
        cyc(1);
        check(fall0 - s);

        // Rise bounce: high 5, low 1, then steady high from e1.
        s = rise0;
        signal_b[0] = 1'b1;
        cyc(5);
        signal_b[0] = 1'b0;
        cyc(1);
        signal_b[0] = 1'b1;
        push_exp("bounce_early_deb",   'b10);
        push_exp("bounce_sticky",      'b01);
        push_exp("bounce_early_count", 0);
        push_exp("bounce_deb",         'b11);
        push_exp("bounce_pulse",       'b01);
        cyc(9);
        check(32'(signal_deb));
        check(32'(glitch_sticky));
        check(rise0 - s);
        cyc(1);
        check(32'(signal_deb));
        check(32'(deb_rise));

        // Active-low ch1 asserts; all_deb follows on the same edge.
        s1 = rise1;
        signal_b[1] = 1'b0;
        push_exp("al_early_deb", 'b11);
        push_exp("al_early_all", 'b0);
        push_exp("al_deb",       'b01);
        push_exp("al_pulse",     'b10);
        push_exp("al_all",       'b1);
        push_exp("al_count",     1);
        cyc(9);
        check(32'(signal_deb));
        check(32'(all_deb));
        cyc(1);
        check(32'(signal_deb));
        check(32'(deb_rise));
        check(32'(all_deb));
        cyc(1);
        check(rise1 - s1);

        // Clear, then glitch_clr coincident with a new fall glitch.
        glitch_clr = 1'b1;
        push_exp("clr2_sticky", 'b00);
        cyc(1);
        glitch_clr = 1'b0;
        check(32'(glitch_sticky));
        signal_b[0] = 1'b0;
        cyc(1);
        signal_b[0] = 1'b1;
        cyc(2);
        glitch_clr = 1'b1;
        push_exp("clr_vs_glitch", 'b01);
        push_exp("clr_vs_glitch_deb", 'b01);
        cyc(1);
        glitch_clr = 1'b0;
        check(32'(glitch_sticky));
        cyc(3);
        check(32'(signal_deb));

        // Sync reset during RISE_QUAL at cnt=6.
        signal_b[0] = 1'b0;
        cyc(8);
        s = rise0;
        signal_b[0] = 1'b1;
        cyc(8);
        rst_n    = 1'b0;
        signal_b = 2'b10;
        cyc(1);
        rst_n = 1'b1;
        push_exp("midrst_deb",    'b10);
        push_exp("midrst_count",  0);
        push_exp("midrst_sticky", 'b00);
        push_exp("midrst_all",    'b0);
        cyc(4);
        check(32'(signal_deb));
        check(rise0 - s);
        check(32'(glitch_sticky));
        check(32'(all_deb));

        // Requalification after reset needs the full latency again.
        signal_b[0] = 1'b1;
        push_exp("requal_early_deb", 'b10);
        push_exp("requal_deb",       'b11);
        cyc(9);
        check(32'(signal_deb));
        cyc(1);
        check(32'(signal_deb));

        // RISE/FALL_VALUE=1, SYNC_STAGES=0: level follows at e0.
        sb_f[0] = 1'b1;
        push_exp("fast_rise_deb",   'b11);
        push_exp("fast_rise_pulse", 'b01);
        cyc(1);
        check(32'(deb_f));
        check(32'(rise_f));
        sb_f[0] = 1'b0;
        push_exp("fast_fall_deb",   'b10);
        push_exp("fast_fall_pulse", 'b01);
        cyc(1);
        check(32'(deb_f));
        check(32'(fall_f));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ipm2t_hssthp_rst_debounce_mc.md
Name: ipm2t_hssthp_rst_debounce_mc

Overview:
Multi-channel, bidirectional debounce filter for HSST reset/status inputs such as PLL lock, CDR lock and signal-detect. Each channel is synchronised, then qualified on both the rising and the falling edge by programmable stable-time counters. Each channel provides a debounced level, edge pulses and glitch reporting. It sits between raw HSST status pins and the reset sequencer FSMs, and replaces per-signal single-direction debouncers.

Parameters:
CH_NUM, 4, number of independent channels (1..32)
CNTR_WIDTH, 12, qualification counter width; must satisfy 2^CNTR_WIDTH > max(RISE_VALUE, FALL_VALUE)
RISE_VALUE, 2048, consecutive asserted samples required to assert (>=1)
FALL_VALUE, 1, consecutive deasserted samples required to deassert (>=1; 1 = immediate)
SYNC_STAGES, 2, input synchroniser depth (0 = input already in clk domain; max 3)
ACTIVE_HIGH, {CH_NUM{1'b0}}, per-channel polarity: bit=0 asserted-high level, bit=1 asserted-low level

Ports:
clk  input  1  single clock for all logic
rst_n  input  1  synchronous, active-low reset, sampled on posedge clk
signal_b  input  CH_NUM  raw status inputs
glitch_clr  input  1  one-cycle clear of glitch_sticky (all channels)
signal_deb  output  CH_NUM  debounced levels, raw polarity
deb_rise  output  CH_NUM  1-cycle pulse when normalised level asserts
deb_fall  output  CH_NUM  1-cycle pulse when normalised level deasserts
glitch_sticky  output  CH_NUM  set on any aborted qualification
all_deb  output  1  AND of all normalised debounced levels

Behaviour:
- Normalisation: n[i] = signal_b[i] ^ ACTIVE_HIGH[i]; internal d[i] is asserted at 1; signal_deb[i] = d[i] ^ ACTIVE_HIGH[i].
- Synchroniser: SYNC_STAGES flops per channel. On reset each flop loads ACTIVE_HIGH[i], so the normalised value is 0. The FSM samples the last stage, n_s.
- Reset (rst_n=0 at posedge): FSM=DEASSERTED, cnt=0, d=0, pulses=0, glitch_sticky=0. Resulting outputs: signal_deb=ACTIVE_HIGH, all_deb=0. Mid-qualification reset aborts with no pulse and no glitch.
- Per-channel FSM, 2-bit encoding:
  DEASSERTED: if n_s=1 then cnt=1. If RISE_VALUE==1, go to ASSERTED, d=1 and fire deb_rise; otherwise go to RISE_QUAL.
  RISE_QUAL: if n_s=1, cnt+1. When cnt+1==RISE_VALUE, go to ASSERTED, d=1, deb_rise=1, cnt=0. If n_s=0, go to DEASSERTED, cnt=0, set glitch_sticky.
  ASSERTED: if n_s=0 then cnt=1. If FALL_VALUE==1, go to DEASSERTED, d=0 and fire deb_fall; otherwise go to FALL_QUAL.
  FALL_QUAL: if n_s=0, cnt+1. When cnt+1==FALL_VALUE, go to DEASSERTED, d=0, deb_fall=1, cnt=0. If n_s=1, go to ASSERTED, cnt=0, set glitch_sticky.
- Latency: let e0 be the first posedge at which signal_b[i] holds the new level and the level stays stable. d changes at edge e0+SYNC_STAGES+VALUE-1, where VALUE is RISE_VALUE or FALL_VALUE. deb_rise/deb_fall are registered, high for exactly the cycle after that edge, aligned with the d change.
- Counter never wraps; cnt is cleared on every state exit.
- glitch_sticky: a set in the same cycle as glitch_clr wins, so the bit stays 1.
- all_deb: registered AND of the d[i] next-state values, so it changes on the same edge as d.
- All outputs are registered; there is no combinational path from input to output.

Decomposition:
- Shared package/include ipm2t_hssthp_rst_pkg: FSM state localparams (DEASSERTED=2'd0, RISE_QUAL=2'd1, ASSERTED=2'd2, FALL_QUAL=2'd3) and the max SYNC_STAGES constant.
- Sub-module ipm2t_hssthp_rst_debounce_ch: one channel, containing the synchroniser, FSM, counter, pulses and sticky bit.
- Top level: generate loop over CH_NUM instances, plus the all_deb register.

Test Plan:
Config for all scenarios unless noted: CH_NUM=2, RISE_VALUE=8, FALL_VALUE=4, SYNC_STAGES=2, ACTIVE_HIGH=2'b10.
1. Reset: hold rst_n=0 3 cycles with random signal_b -> signal_deb=2'b10, all pulses 0, glitch_sticky=0, all_deb=0.
2. Clean rise: ch0 0->1 first sampled at e0 -> signal_deb[0] rises at e0+9, deb_rise[0]=1 for one cycle, glitch_sticky[0]=0.
3. Rise bounce: ch0 high 5 cycles, low 1, high steady -> glitch_sticky[0]=1; signal_deb[0] rises 9 edges after the second rise is first sampled; no deb_rise earlier.
4. Fall filter: ch0 asserted, low 3 cycles then high -> stays asserted, glitch_sticky[0]=1. Then low steady -> signal_deb[0] falls at e0+5, deb_fall[0] pulses.
5. Active-low channel: ch1 1->0 steady -> signal_deb[1] 1->0 at e0+9, deb_rise[1] pulses. With ch0 already asserted, all_deb=1 on the same edge.
6. Corner: glitch_clr in the same cycle as a new glitch -> glitch_sticky stays 1. Sync reset during RISE_QUAL at cnt=6 -> cnt=0, no pulse. Also run with RISE_VALUE=1, SYNC_STAGES=0 -> d follows at e0.
